// File: rtl/fetch_stage_pkg.sv
// Shared opcode and constant definitions for the fetch stage: reset PC,
// bubble instruction and FSM state encoding.
package fetch_stage_pkg;

    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0]  F3_ADDI    = 3'b000;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    // addi x0, x0, 0 -- the canonical RISC-V nop
    localparam logic [31:0] NOP_INST_DEF = {12'd0, 5'd0, F3_ADDI, 5'd0, OPC_OP_IMM};

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response and IF/ID output bundle.
// master = fetch stage, slave = memory plus decode.
interface fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic        if_id_valid;

    modport master (
        output imem_req, imem_addr, if_id_inst, if_id_pc, if_id_valid,
        input  imem_ready, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, if_id_inst, if_id_pc, if_id_valid,
        output imem_ready, imem_rdata
    );

endinterface

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: load a fetched word, load a bubble, or hold.
// Bubble wins over load if both are raised.
module if_id_register #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_valid
);

    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic        r_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst  <= NOP_INST;
            r_pc    <= 32'd0;
            r_valid <= 1'b0;
        end else if (i_bubble) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_inst  <= i_inst;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end
    end

    assign o_inst  = r_inst;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and FETCH/HALTED FSM
// feeding the IF/ID register. Priority: halt > redirect > stall > imem_ready.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    input  logic                 halt,
    fetch_stage_if.master        bus
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_redirect_aligned;
    logic         w_load;
    logic         w_bubble;

    assign w_redirect_aligned = redirect_pc & ~32'h0000_0003;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (halt) begin
                    w_state_next = ST_HALTED;
                    w_bubble     = 1'b1;
                end else if (redirect_valid) begin
                    // Any imem_ready this cycle belongs to the squashed path.
                    w_pc_next = w_redirect_aligned;
                    w_bubble  = 1'b1;
                end else if (stall) begin
                    w_pc_next = r_pc;
                end else if (bus.imem_ready) begin
                    w_load    = 1'b1;
                    w_pc_next = r_pc + 32'd4;
                end else begin
                    w_bubble = 1'b1;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    assign bus.imem_req  = (r_state == ST_FETCH);
    assign bus.imem_addr = r_pc;

    if_id_register #(
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_inst   (bus.imem_rdata),
        .i_pc     (r_pc),
        .o_inst   (bus.if_id_inst),
        .o_pc     (bus.if_id_pc),
        .o_valid  (bus.if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes model predictions,
// a monitor pops and compares one entry after every rising edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
        logic        req;
        logic [31:0] addr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .bus            (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    // Reference model: architectural view of the stage.
    logic [31:0] m_pc;
    logic        m_halted;
    logic [31:0] m_inst;
    logic [31:0] m_ifpc;
    logic        m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    endtask

    task automatic model_reset();
        m_pc     = 32'h0000_0000;
        m_halted = 1'b0;
        m_inst   = NOP;
        m_ifpc   = 32'd0;
        m_valid  = 1'b0;
    endtask

    // Called just after a falling edge: drive inputs, predict the post-edge
    // state, then advance to the next falling edge.
    task automatic cycle(input logic st, input logic rv, input logic [31:0] rpc,
                         input logic h, input logic rdy, input logic [31:0] rdata);
        exp_t e;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = h;
        bus.imem_ready = rdy;
        bus.imem_rdata = rdata;
        if (!m_halted) begin
            if (h) begin
                m_halted = 1'b1;
                m_inst   = NOP;
                m_valid  = 1'b0;
            end else if (rv) begin
                m_pc    = {rpc[31:2], 2'b00};
                m_inst  = NOP;
                m_valid = 1'b0;
            end else if (st) begin
                m_pc = m_pc;
            end else if (rdy) begin
                m_inst  = rdata;
                m_ifpc  = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end else begin
                m_inst  = NOP;
                m_valid = 1'b0;
            end
        end
        e.inst  = m_inst;
        e.pc    = m_ifpc;
        e.valid = m_valid;
        e.req   = !m_halted;
        e.addr  = m_pc;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_reset_values();
        check("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
        check("rst_inst", bus.if_id_inst, NOP);
        check("rst_ifpc", bus.if_id_pc, 32'd0);
        check("rst_req", {31'd0, bus.imem_req}, 32'd1);
        check("rst_addr", bus.imem_addr, 32'h0000_0000);
    endtask

    // Asserted between edges: outputs must respond without a clock.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("if_id_inst", bus.if_id_inst, e.inst);
                check("if_id_pc", bus.if_id_pc, e.pc);
                check("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, e.valid});
                check("imem_req", {31'd0, bus.imem_req}, {31'd0, e.req});
                check("imem_addr", bus.imem_addr, e.addr);
            end
        end
    end

    initial begin : stimulus
        logic [31:0] rpc;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        halt           = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_values();
        reset = 1'b0;

        // Three back-to-back accepts: if_id_pc 0, 4, 8.
        cycle(0, 0, 0, 0, 1, 32'hA000_0000);
        cycle(0, 0, 0, 0, 1, 32'hA000_0004);
        cycle(0, 0, 0, 0, 1, 32'hA000_0008);
        // Stall holding pc=8 with if_id_pc=4, then release.
        do_reset();
        cycle(0, 0, 0, 0, 1, 32'hB000_0000);
        cycle(0, 0, 0, 0, 1, 32'hB000_0004);
        cycle(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
        cycle(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
        cycle(0, 0, 0, 0, 1, 32'hB000_0008);
        // Redirect beats stall; low target bits dropped.
        cycle(1, 1, 32'h0000_0103, 0, 1, 32'hDEAD_BEEF);
        // Three memory waits, then the word arrives.
        cycle(0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        cycle(0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        cycle(0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        cycle(0, 0, 0, 0, 1, 32'hC000_0100);
        // PC wrap at the top of the address space.
        cycle(0, 1, 32'hFFFF_FFFC, 0, 0, 32'd0);
        cycle(0, 0, 0, 0, 1, 32'hE000_FFFC);
        cycle(0, 0, 0, 0, 1, 32'hE000_0000);
        // Halt beats redirect; HALTED is absorbing; reset resumes at 0.
        cycle(0, 1, 32'h0000_4000, 1, 1, 32'hDEAD_BEEF);
        cycle(0, 1, 32'h0000_8000, 0, 1, 32'h1111_1111);
        cycle(0, 0, 0, 0, 1, 32'h2222_2222);
        cycle(1, 0, 0, 1, 0, 32'h3333_3333);
        do_reset();
        cycle(0, 0, 0, 0, 1, 32'hF000_0000);
        cycle(0, 0, 0, 0, 1, 32'hF000_0004);

        // Randomized traffic, with resets landing mid-stall/mid-wait/halted.
        for (int i = 0; i < 2000; i++) begin
            if ((m_halted && ($urandom % 6 == 0)) || ($urandom % 250 == 0)) begin
                do_reset();
            end else begin
                rpc = $urandom;
                if ($urandom % 4 == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
                cycle(($urandom % 4) == 0, ($urandom % 8) == 0, rpc,
                      ($urandom % 150) == 0, ($urandom % 4) != 0, $urandom);
            end
        end

        stall          = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the instruction word (addi x0,x0,0) driven on if_id_inst for a bubble.
REQ-003 SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have the port reset, input, 1 bit: the asynchronous, active-high reset.
REQ-005 SHALL have the port stall, input, 1 bit: the hazard-unit hold request; freezes the PC and the IF/ID register.
REQ-006 SHALL have the port redirect_valid, input, 1 bit: a taken branch, jump or mispredict resolved in EX.
REQ-007 SHALL have the port redirect_pc, input, 32 bits: the redirect target.
REQ-008 SHALL have the port halt, input, 1 bit: the terminating ECALL has been confirmed downstream.
REQ-009 SHALL have the port imem_req, output, 1 bit: the instruction-memory read request.
REQ-010 SHALL have the port imem_addr, output, 32 bits: the fetch address, which equals the PC.
REQ-011 SHALL have the port imem_ready, input, 1 bit: imem_rdata is valid this cycle; tied to 1 for single-cycle memory.
REQ-012 SHALL have the port imem_rdata, input, 32 bits: the fetched instruction word.
REQ-013 SHALL have the port if_id_inst, output, 32 bits: the instruction word presented to decode and immediate generation.
REQ-014 SHALL have the port if_id_pc, output, 32 bits: the PC of if_id_inst.
REQ-015 SHALL have the port if_id_valid, output, 1 bit: if_id_inst is a real instruction; 0 means bubble.

Function
REQ-016 SHALL implement a two-state FSM: FETCH and HALTED.
REQ-017 In FETCH, SHALL drive imem_req=1 and imem_addr=pc; in HALTED, SHALL drive imem_req=0.
REQ-018 Accept (FETCH, imem_ready=1, stall=0, redirect_valid=0): SHALL load if_id_inst<=imem_rdata, if_id_pc<=pc, if_id_valid<=1, pc<=pc+4.
REQ-019 Stall (stall=1, redirect_valid=0): SHALL hold pc, if_id_inst, if_id_pc and if_id_valid, and SHALL discard the returned imem_rdata; the same address is re-requested.
REQ-020 Memory wait (FETCH, imem_ready=0, stall=0, redirect_valid=0): SHALL hold pc and SHALL load a bubble (if_id_valid<=0, if_id_inst<=NOP_INST).
REQ-021 Redirect (redirect_valid=1): SHALL set pc<=redirect_pc with bits [1:0] forced to 0 and SHALL load a bubble; redirect takes priority over stall and imem_ready.
REQ-022 Halt: halt=1 SHALL move FETCH to HALTED at the next edge and load a bubble; halt SHALL take priority over redirect and stall.
REQ-023 HALTED SHALL be absorbing until reset; pc and IF/ID contents SHALL hold with if_id_valid=0.
REQ-024 PC arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC+4 -> 32'h0000_0000) with no error flag.
REQ-025 Fetch latency SHALL be one cycle from imem_ready=1 to the corresponding if_id_valid=1.
REQ-026 An imem_ready pulse arriving while redirect_valid=1 SHALL be dropped, never latched.

Reset
REQ-027 While reset=1, the block SHALL force pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_inst=NOP_INST and if_id_pc=0, asynchronously.
REQ-028 Reset asserted mid-wait or mid-stall SHALL abandon the outstanding request; the first request after deassertion SHALL use RESET_PC.

Structure
REQ-029 RESET_PC, NOP_INST and the FSM state encodings SHALL live in the shared opcode/constant include, alongside the opcode definitions.
REQ-030 The IF/ID register (inst, pc, valid, with hold and bubble controls) SHALL be a sub-module named if_id_register; the PC register, next-PC selection and FSM SHALL stay in fetch_stage.

Verification
REQ-031 Reset, then imem_ready=1 for 3 cycles -> if_id_pc = 0, 4, 8 on consecutive cycles with if_id_valid=1.
REQ-032 stall=1 for 2 cycles at pc=8 -> imem_addr stays 8 and if_id_pc stays 4 and valid; after release, if_id_pc=8.
REQ-033 redirect_valid=1, stall=1 and redirect_pc=32'h0000_0103 in the same cycle -> next pc=32'h100 and bubble (valid=0, inst=32'h13).
REQ-034 imem_ready=0 for 3 cycles -> three bubbles, pc held; ready returns -> the instruction is latched with the correct pc.
REQ-035 halt=1 with redirect_valid=1 -> HALTED, imem_req=0 thereafter, valid=0; reset -> fetch resumes at 0.
REQ-036 Redirect to 32'hFFFF_FFFC then accept two fetches -> if_id_pc = FFFF_FFFC then 0000_0000.
